// File: rtl/aes_dec_arbiter.sv
// Two-requester front end for one shared AES decryption core: round-robin grant,
// one job in flight, stale-done blanking, timeout abort and held result handshake.
module aes_dec_arbiter #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [127:0] req0_data,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [127:0] req1_data,
  output logic         core_start,
  output logic [127:0] core_data_in,
  input  logic         core_done,
  input  logic [127:0] core_data_out,
  output logic         rsp0_valid,
  input  logic         rsp0_ready,
  output logic [127:0] rsp0_data,
  output logic         rsp0_err,
  output logic         rsp1_valid,
  input  logic         rsp1_ready,
  output logic [127:0] rsp1_data,
  output logic         rsp1_err,
  output logic         busy
);

  localparam int unsigned DW = 128;
  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]    state, state_n;
  logic [DW-1:0] hold, hold_n;
  logic [DW-1:0] result, result_n;
  logic          err, err_n;
  logic          owner, owner_n;
  logic          last_grant, last_grant_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [CW-1:0] cnt_inc;
  logic          start_q, busy_q, rsp0_valid_q, rsp1_valid_q;
  logic          grant_any, grant_id;

  // Combinational grant: a lone requester wins, a tie goes to the one not served last.
  always_comb begin
    grant_any = req0_valid | req1_valid;
    grant_id  = req1_valid;
    if (req0_valid && req1_valid) begin
      grant_id = ~last_grant;
    end
  end

  assign req0_ready = ~reset & (state == S_IDLE) & req0_valid & ~grant_id;
  assign req1_ready = ~reset & (state == S_IDLE) & req1_valid & grant_id;

  assign cnt_inc = cnt + CW'(1);

  always_comb begin
    state_n      = state;
    hold_n       = hold;
    result_n     = result;
    err_n        = err;
    owner_n      = owner;
    last_grant_n = last_grant;
    cnt_n        = cnt;
    case (state)
      S_IDLE: begin
        if (grant_any) begin
          hold_n  = grant_id ? req1_data : req0_data;
          owner_n = grant_id;
          state_n = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_n   = '0;
        state_n = S_WAIT;
      end
      S_WAIT: begin
        cnt_n = cnt_inc;
        // cnt==0 marks the first WAIT cycle, where done may be left over from the last job.
        if ((cnt != '0) && core_done) begin
          result_n = core_data_out;
          err_n    = 1'b0;
          state_n  = S_RESP;
        end else if (cnt_inc == CNT_LAST) begin
          result_n = '0;
          err_n    = 1'b1;
          state_n  = S_RESP;
        end
      end
      S_RESP: begin
        if (owner ? rsp1_ready : rsp0_ready) begin
          last_grant_n = owner;
          state_n      = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      hold         <= '0;
      result       <= '0;
      err          <= 1'b0;
      owner        <= 1'b0;
      last_grant   <= 1'b1;
      cnt          <= '0;
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
    end else begin
      state        <= state_n;
      hold         <= hold_n;
      result       <= result_n;
      err          <= err_n;
      owner        <= owner_n;
      last_grant   <= last_grant_n;
      cnt          <= cnt_n;
      start_q      <= (state_n == S_ISSUE);
      busy_q       <= (state_n != S_IDLE);
      rsp0_valid_q <= (state_n == S_RESP) & ~owner_n;
      rsp1_valid_q <= (state_n == S_RESP) & owner_n;
    end
  end

  assign core_start   = start_q;
  assign core_data_in = hold;
  assign busy         = busy_q;
  assign rsp0_valid   = rsp0_valid_q;
  assign rsp1_valid   = rsp1_valid_q;
  assign rsp0_data    = result;
  assign rsp1_data    = result;
  assign rsp0_err     = err;
  assign rsp1_err     = err;

endmodule

// File: tb/tb_aes_dec_arbiter.sv
// Bench for aes_dec_arbiter: directed scenarios plus randomized jobs checked
// against a job-level model (grant rule, latency arithmetic, expected result).
module tb_aes_dec_arbiter;

  localparam int TO_TB = 8;

  logic         clock;
  logic         reset;
  logic [1:0]   req_v;
  logic [1:0]   req_rdy;
  logic [127:0] req_d [2];
  logic         core_start;
  logic [127:0] core_data_in;
  logic         core_done;
  logic [127:0] core_data_out;
  logic [1:0]   rsp_v;
  logic [1:0]   rsp_rdy;
  logic [127:0] rsp_d [2];
  logic [1:0]   rsp_e;
  logic         busy;

  int   checks;
  int   failures;
  logic m_last;

  aes_dec_arbiter #(.TIMEOUT(TO_TB)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req_v[0]), .req0_ready(req_rdy[0]), .req0_data(req_d[0]),
    .req1_valid(req_v[1]), .req1_ready(req_rdy[1]), .req1_data(req_d[1]),
    .core_start(core_start), .core_data_in(core_data_in),
    .core_done(core_done), .core_data_out(core_data_out),
    .rsp0_valid(rsp_v[0]), .rsp0_ready(rsp_rdy[0]), .rsp0_data(rsp_d[0]), .rsp0_err(rsp_e[0]),
    .rsp1_valid(rsp_v[1]), .rsp1_ready(rsp_rdy[1]), .rsp1_data(rsp_d[1]), .rsp1_err(rsp_e[1]),
    .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_w(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_v(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One complete job: core raises done d cycles after the core_start cycle;
  // success iff the done lands before the timeout window closes.
  task automatic run_job(input logic id, input logic both, input logic [127:0] ct,
                         input logic [127:0] pt, input int d, input int hold);
    int         exp_at;
    logic       ok;
    logic [1:0] own;
    ok     = (d <= TO_TB - 1);
    exp_at = ok ? d + 1 : TO_TB;
    own    = id ? 2'b10 : 2'b01;
    req_d[id]  = ct;
    req_d[~id] = rnd128();
    req_v      = both ? 2'b11 : own;
    core_done     = 1'b0;
    core_data_out = rnd128();
    #1;
    chk_v("grant", req_rdy, own);
    tick();
    if (both) req_d[id] = rnd128();
    else      req_v = 2'b00;
    chk_b("core_start", core_start, 1'b1);
    chk_w("core_data_in", core_data_in, ct);
    chk_b("busy_issue", busy, 1'b1);
    chk_v("ready_issue", req_rdy, 2'b00);
    for (int c = 1; c < exp_at; c++) begin
      tick();
      chk_v("rsp_early", rsp_v, 2'b00);
      chk_b("start_once", core_start, 1'b0);
      chk_w("data_in_hold", core_data_in, ct);
      chk_v("ready_busy", req_rdy, 2'b00);
      if (c == d) begin
        core_done     = 1'b1;
        core_data_out = pt;
      end
    end
    tick();
    for (int h = 0; h <= hold; h++) begin
      chk_v("rsp_valid", rsp_v, own);
      chk_w("rsp_data", rsp_d[id], ok ? pt : '0);
      chk_b("rsp_err", rsp_e[id], ~ok);
      chk_v("ready_resp", req_rdy, 2'b00);
      if (h < hold) tick();
    end
    rsp_rdy = own;
    #1;
    chk_v("ready_hs", req_rdy, 2'b00);
    tick();
    rsp_rdy = 2'b00;
    req_v   = 2'b00;
    chk_v("rsp_drop", rsp_v, 2'b00);
    chk_b("busy_idle", busy, 1'b0);
    m_last = id;
  endtask

  initial begin
    logic [1:0] mask;
    logic       id;
    checks = 0; failures = 0;
    reset = 1'b1; req_v = 2'b11; rsp_rdy = 2'b11;
    req_d[0] = rnd128(); req_d[1] = rnd128();
    core_done = 1'b1; core_data_out = rnd128();
    tick(); tick();
    chk_v("rst_ready", req_rdy, 2'b00);
    chk_v("rst_rsp_valid", rsp_v, 2'b00);
    chk_v("rst_rsp_err", rsp_e, 2'b00);
    chk_b("rst_busy", busy, 1'b0);
    chk_b("rst_start", core_start, 1'b0);
    chk_w("rst_data_in", core_data_in, '0);
    chk_w("rst_rsp0_data", rsp_d[0], '0);
    chk_w("rst_rsp1_data", rsp_d[1], '0);
    reset = 1'b0; req_v = 2'b00; rsp_rdy = 2'b00; core_done = 1'b0;
    m_last = 1'b1;

    // Single job with known vectors, minimum latency and one backpressure cycle.
    run_job(1'b0, 1'b0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
            128'h00112233445566778899aabbccddeeff, 2, 1);

    // Done left high from a prior job must not complete the next one.
    req_v = 2'b10; req_d[1] = 128'hcafe; core_done = 1'b1; core_data_out = 128'hdead;
    #1;
    chk_v("stale_grant", req_rdy, 2'b10);
    tick();
    req_v = 2'b00;
    chk_b("stale_start", core_start, 1'b1);
    tick();
    chk_v("stale_blank", rsp_v, 2'b00);
    tick();
    core_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk_v("stale_low", rsp_v, 2'b00);
      tick();
    end
    core_done = 1'b1; core_data_out = 128'h0123_4567_89ab_cdef;
    chk_v("stale_pre", rsp_v, 2'b00);
    tick();
    chk_v("stale_valid", rsp_v, 2'b10);
    chk_w("stale_data", rsp_d[1], 128'h0123_4567_89ab_cdef);
    chk_b("stale_err", rsp_e[1], 1'b0);
    rsp_rdy = 2'b10;
    tick();
    rsp_rdy = 2'b00; core_done = 1'b0;
    chk_v("stale_drop", rsp_v, 2'b00);
    m_last = 1'b1;

    // Timeout on requester 1, then normal jobs.
    run_job(1'b1, 1'b0, rnd128(), rnd128(), 40, 0);
    run_job(1'b0, 1'b0, rnd128(), rnd128(), 3, 0);
    run_job(1'b1, 1'b0, rnd128(), rnd128(), TO_TB - 1, 0);

    // Backpressure on rsp0 while req1 waits.
    run_job(1'b0, 1'b1, rnd128(), rnd128(), 4, 10);
    run_job(1'b1, 1'b1, rnd128(), rnd128(), 2, 0);

    // Reset during WAIT abandons the job.
    req_v = 2'b01; req_d[0] = rnd128(); core_done = 1'b0;
    tick();
    req_v = 2'b00;
    tick(); tick();
    reset = 1'b1;
    #1;
    chk_b("rstw_busy", busy, 1'b0);
    chk_v("rstw_rsp", rsp_v, 2'b00);
    chk_b("rstw_start", core_start, 1'b0);
    chk_w("rstw_data_in", core_data_in, '0);
    tick();
    reset = 1'b0; m_last = 1'b1;
    core_done = 1'b1; core_data_out = rnd128();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_v("rstw_no_rsp", rsp_v, 2'b00);
      chk_b("rstw_idle", busy, 1'b0);
    end
    run_job(1'b0, 1'b0, rnd128(), rnd128(), 2, 0);

    // Both requesters valid from reset: grants must alternate.
    reset = 1'b1; req_v = 2'b11;
    tick();
    chk_v("fair_rst_ready", req_rdy, 2'b00);
    reset = 1'b0; m_last = 1'b1;
    for (int j = 0; j < 4; j++) begin
      run_job(j[0], 1'b1, rnd128(), rnd128(), 2, 0);
    end

    // Randomized jobs against the job-level model.
    for (int j = 0; j < 30; j++) begin
      mask = 2'($urandom_range(1, 3));
      id   = (mask == 2'b11) ? ~m_last : mask[1];
      run_job(id, mask == 2'b11, rnd128(), rnd128(),
              int'($urandom_range(2, 11)), int'($urandom_range(0, 3)));
      for (int g = int'($urandom_range(0, 2)); g > 0; g--) begin
        tick();
        chk_b("gap_idle", busy, 1'b0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
